// File: rtl/alu_pkg.sv
// Shared definitions for the step-driven ALU: data width, opcodes and the
// sequencer FSM encoding.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_STR   = 4'h2;
  localparam logic [3:0] OP_WRITE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // True for opcodes whose result lands in the accumulator and the flags.
  function automatic logic writes_acc(input logic [3:0] op);
    return (op == OP_LDI) || ((op >= OP_ADD) && (op <= OP_XOR));
  endfunction

endpackage

// File: rtl/alu_step_sequencer_if.sv
// Board-side bundle: step switch and instruction switches in, LED outputs
// and the busy indicator out.
interface alu_step_sequencer_if;
  import alu_pkg::*;

  logic              STEP;
  logic [DATA_W-1:0] INSTR;
  logic [DATA_W-1:0] DOUT;
  logic              SIG1;
  logic              SIG2;
  logic              BUSY;

  // Switch board / stimulus side.
  modport master (output STEP, INSTR, input DOUT, SIG1, SIG2, BUSY);
  // Sequencer side.
  modport slave  (input STEP, INSTR, output DOUT, SIG1, SIG2, BUSY);
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU shared by every operation of the sequencer.
// Opcodes that do not compute pass the A operand through with carry clear.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};

  // Select the result and carry/borrow for the current opcode.
  always_comb begin
    // NOTE: defaults first so every path assigns y and c; otherwise a latch is inferred.
    y = a;
    c = 1'b0;
    case (op)
      OP_LDI: y = b;
      OP_ADD: {c, y} = w_sum;
      OP_SUB: begin
        y = a - b;
        c = (a < b);
      end
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/alu_step_sequencer.sv
// Single-step sequencer: synchronizes and debounces the step switch, then
// runs one FETCH/EXEC/WB pass per debounced press over the instruction on
// the data switches. Owns ACC, R[0..3], DOUT and the carry/zero flags.
module alu_step_sequencer
  import alu_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_step_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]        r_sync;
  logic              r_deb;
  logic              r_deb_d;
  logic [CNT_W-1:0]  r_cnt;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] r_dout;
  logic              r_c;
  logic              r_z;
  logic [DATA_W-1:0] r_res;
  logic              r_res_c;
  logic              r_res_z;

  logic              w_press;
  logic [3:0]        w_op;
  logic [1:0]        w_r;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_y;
  logic              w_c;
  logic              w_z;

  assign w_press = r_deb & ~r_deb_d;
  assign w_op    = r_ir[7:4];
  assign w_r     = r_ir[1:0];
  assign w_b     = (w_op == OP_LDI) ? {{(DATA_W-4){1'b0}}, r_ir[3:0]} : r_regs[w_r];

  // Synchronize STEP, accept a new level only after DEB_CYCLES stable mismatches.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (RST) begin
      r_sync  <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], bus.STEP};
      r_deb_d <= r_deb;
      if (r_sync[1] != r_deb) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: presses outside IDLE fall through and are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_press) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_WB;
      ST_WB:    w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  alu_core u_alu_core (
    .op (w_op),
    .a  (r_acc),
    .b  (w_b),
    .y  (w_y),
    .c  (w_c),
    .z  (w_z)
  );

  // Latch IR, register the ALU result, then commit architectural state in WB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the register file is reset explicitly because its contents are architecturally visible after reset.
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_res   <= '0;
      r_res_c <= 1'b0;
      r_res_z <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: r_ir <= bus.INSTR;
        ST_EXEC: begin
          r_res   <= w_y;
          r_res_c <= w_c;
          r_res_z <= w_z;
        end
        ST_WB: begin
          if (writes_acc(w_op)) begin
            r_acc <= r_res;
            r_c   <= r_res_c;
            r_z   <= r_res_z;
          end else if (w_op == OP_STR) begin
            r_regs[w_r] <= r_acc;
          end else if (w_op == OP_WRITE) begin
            r_dout <= r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.DOUT = r_dout;
  assign bus.SIG1 = r_c;
  assign bus.SIG2 = r_z;
  assign bus.BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: directed vector table, multi-cycle corner
// sequences (bounce, glitch, dropped press, reset mid-instruction) and
// random instructions checked against a plain-arithmetic reference model.
module tb_alu_step_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  alu_step_sequencer_if bus ();
  alu_step_sequencer_if bus_f ();

  alu_step_sequencer #(.DEB_CYCLES(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Fast-debounce copy: lets a second debounced press land while BUSY.
  alu_step_sequencer #(.DEB_CYCLES(1)) dut_fast (
    .CLK (clk),
    .RST (rst),
    .bus (bus_f)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Count BUSY rising edges on both instances.
  int   starts = 0, starts_f = 0;
  logic busy_q = 1'b0, busy_f_q = 1'b0;
  always @(negedge clk) begin
    if (bus.BUSY === 1'b1 && !busy_q) starts++;
    if (bus_f.BUSY === 1'b1 && !busy_f_q) starts_f++;
    busy_q   = (bus.BUSY === 1'b1);
    busy_f_q = (bus_f.BUSY === 1'b1);
  end

  // Reference model: architectural state as plain integers.
  int m_acc, m_dout, m_c, m_z;
  int m_r [4];

  function automatic void model_reset();
    m_acc = 0; m_dout = 0; m_c = 0; m_z = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endfunction

  function automatic void model_step(input logic [7:0] instr);
    int op = int'(instr[7:4]);
    int r  = int'(instr[1:0]);
    int b  = m_r[r];
    bit wr = 1'b1;
    case (op)
      1: begin m_acc = int'(instr[3:0]); m_c = 0; end
      2: begin m_r[r] = m_acc; wr = 1'b0; end
      3: begin m_dout = m_acc; wr = 1'b0; end
      4: begin m_c = (m_acc + b > 255); m_acc = (m_acc + b) % 256; end
      5: begin m_c = (m_acc < b); m_acc = (m_acc - b + 256) % 256; end
      6: begin m_acc = 255 - m_acc; m_c = 0; end
      7: begin m_acc = m_acc & b; m_c = 0; end
      8: begin m_acc = m_acc | b; m_c = 0; end
      9: begin m_acc = m_acc ^ b; m_c = 0; end
      default: wr = 1'b0;
    endcase
    if (wr) m_z = (m_acc == 0);
  endfunction

  // One clean press on the main instance: checks debounce latency and BUSY
  // width, scrambles INSTR after FETCH, then releases and lets it settle.
  task automatic press(input logic [7:0] instr, input string tag);
    int lat = 0;
    int len = 0;
    @(negedge clk);
    bus.INSTR = instr;
    bus.STEP  = 1'b1;
    while (bus.BUSY !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 7);
    if (bus.BUSY === 1'b1) begin
      while (bus.BUSY === 1'b1 && len < 10) begin
        @(negedge clk);
        len++;
        if (len == 1) bus.INSTR = ~instr;
      end
      check({tag, "_busy_len"}, len, 3);
    end
    bus.STEP = 1'b0;
    model_step(instr);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_acc"},  dut.r_acc, m_acc);
    check({tag, "_dout"}, bus.DOUT,  m_dout);
    check({tag, "_sig1"}, bus.SIG1,  m_c);
    check({tag, "_sig2"}, bus.SIG2,  m_z);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [7:0] acc;
    logic [7:0] dout;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [22];

  initial begin
    int s0;
    string tag;

    vecs[0]  = '{8'h1D, 8'h0D, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h20, 8'h0D, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h17, 8'h07, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{8'h40, 8'h14, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h50, 8'h07, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'h60, 8'hF8, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h70, 8'h08, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 8'h0D, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'h90, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{8'h30, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{8'h1F, 8'h0F, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{8'h21, 8'h0F, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{8'h60, 8'hF0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{8'h41, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{8'h41, 8'h0E, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{8'h1F, 8'h0F, 8'h00, 1'b0, 1'b0};
    vecs[16] = '{8'h51, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[17] = '{8'h12, 8'h02, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{8'h51, 8'hF3, 8'h00, 1'b1, 1'b0};
    vecs[19] = '{8'h30, 8'hF3, 8'hF3, 1'b1, 1'b0};
    vecs[20] = '{8'h00, 8'hF3, 8'hF3, 1'b1, 1'b0};
    vecs[21] = '{8'hF3, 8'hF3, 8'hF3, 1'b1, 1'b0};

    rst = 1'b1;
    bus.STEP = 1'b0;   bus.INSTR = 8'h00;
    bus_f.STEP = 1'b0; bus_f.INSTR = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_acc",  dut.r_acc,       8'h00);
    check("reset_r0",   dut.r_regs[0],   8'h00);
    check("reset_dout", bus.DOUT,        8'h00);
    check("reset_sig1", bus.SIG1,        1'b0);
    check("reset_sig2", bus.SIG2,        1'b0);
    check("reset_busy", bus.BUSY,        1'b0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Directed program from the test plan, including carry/borrow and no-ops.
    for (int i = 0; i < 22; i++) begin
      tag = $sformatf("vec%0d", i);
      press(vecs[i].instr, tag);
      check({tag, "_acc"},  dut.r_acc, vecs[i].acc);
      check({tag, "_dout"}, bus.DOUT,  vecs[i].dout);
      check({tag, "_sig1"}, bus.SIG1,  vecs[i].c);
      check({tag, "_sig2"}, bus.SIG2,  vecs[i].z);
    end
    check("prog_r0", dut.r_regs[0], 8'h0D);
    check("prog_r1", dut.r_regs[1], 8'h0F);

    // Bounce: toggles every 2 cycles for 20 cycles, then stable high.
    s0 = starts;
    @(negedge clk);
    bus.INSTR = 8'h1C;
    for (int i = 0; i < 10; i++) begin
      bus.STEP = ~bus.STEP;
      repeat (2) @(negedge clk);
    end
    bus.STEP = 1'b1;
    repeat (20) @(negedge clk);
    bus.STEP = 1'b0;
    repeat (10) @(negedge clk);
    model_step(8'h1C);
    check("bounce_starts", starts - s0, 1);
    check("bounce_acc", dut.r_acc, 8'h0C);

    // Glitch shorter than the debounce window.
    s0 = starts;
    bus.INSTR = 8'h17;
    bus.STEP = 1'b1;
    repeat (3) @(negedge clk);
    bus.STEP = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_starts", starts - s0, 0);
    check("glitch_acc", dut.r_acc, 8'h0C);

    // Second debounced press while BUSY on the fast instance is dropped.
    s0 = starts_f;
    bus_f.INSTR = 8'h1A;
    bus_f.STEP = 1'b1;
    @(negedge clk);
    bus_f.STEP = 1'b0;
    @(negedge clk);
    bus_f.STEP = 1'b1;
    repeat (15) @(negedge clk);
    bus_f.STEP = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_starts", starts_f - s0, 1);
    check("drop_acc", dut_fast.r_acc, 8'h0A);

    // Put non-zero state everywhere, then reset during EXEC of an ADD.
    press(8'h30, "pre_wr");
    press(8'h20, "pre_str");
    check_model("pre_reset");
    s0 = 0;
    @(negedge clk);
    bus.INSTR = 8'h40;
    bus.STEP  = 1'b1;
    while (bus.BUSY !== 1'b1 && s0 < 40) begin
      @(negedge clk);
      s0++;
    end
    check("rst_add_latency", s0, 7);
    @(negedge clk);
    rst = 1'b1;
    bus.STEP = 1'b0;
    @(negedge clk);
    check("rst_exec_busy", bus.BUSY,     1'b0);
    check("rst_exec_acc",  dut.r_acc,    8'h00);
    check("rst_exec_r0",   dut.r_regs[0], 8'h00);
    check("rst_exec_dout", bus.DOUT,     8'h00);
    check("rst_exec_sig1", bus.SIG1,     1'b0);
    check("rst_exec_sig2", bus.SIG2,     1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    press(8'h1A, "post_rst");
    check("post_rst_acc", dut.r_acc, 8'h0A);
    check_model("post_rst");

    // Random instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ins;
      ins = 8'($urandom_range(0, 255));
      tag = $sformatf("rnd%0d", i);
      press(ins, tag);
      check_model(tag);
    end
    for (int i = 0; i < 4; i++) check($sformatf("rnd_r%0d", i), dut.r_regs[i], m_r[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Single-step instruction sequencer for the 8-bit switch-driven ALU. It turns each debounced press of the step switch into one fetch/execute/writeback pass over the 8-bit instruction on the data switches. It owns the accumulator, a 4-entry operand register file and the carry/zero flags, and shares one combinational ALU core across all operations. It sits between the board switches and the LED output (DOUT, SIG1, SIG2) at the top of the design.

## Interface
- DEB_CYCLES, 4: consecutive stable cycles required before a synchronized STEP level is accepted (set to 4 for simulation, larger on the board).
- CLK  in  1  system clock; all state on the rising edge.
- RST  in  1  synchronous, active-high reset.
- STEP  in  1  raw step switch (asynchronous, bouncing).
- INSTR  in  8  instruction switches; [7:4] opcode, [3:0] operand.
- DOUT  out  8  output register, written only by WRITE.
- SIG1  out  1  carry/borrow flag.
- SIG2  out  1  zero flag.
- BUSY  out  1  high whenever FSM not in IDLE.

## Operation
Instruction set (opcode: effect; r = INSTR[1:0]):
- 0x1 LDI: ACC <= {4'h0, INSTR[3:0]}; Z updated, C <= 0.
- 0x2 STR: R[r] <= ACC; flags unchanged.
- 0x3 WRITE: DOUT <= ACC; flags unchanged.
- 0x4 ADD: {C, ACC} <= ACC + R[r]; carry-out of the 9-bit sum.
- 0x5 SUB: ACC <= ACC - R[r] mod 256; C <= (ACC < R[r]) as unsigned borrow.
- 0x6 NOT: ACC <= ~ACC; C <= 0.
- 0x7 AND, 0x8 OR, 0x9 XOR: ACC <= ACC op R[r]; C <= 0.
- Z <= (new ACC == 0) for every ACC-writing opcode (0x1, 0x4–0x9).
- 0x0 and 0xA–0xF: no-op. The FSM still passes through all states; no state changes.

Step input path:
- 2-FF synchronizer feeds a debounce counter.
- The debounced level changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles. The counter clears on any mismatch gap.
- A 0->1 transition of the debounced level is a press. 1->0 is ignored.

FSM states:
- IDLE: a press moves to FETCH; otherwise stay.
- FETCH: latch INSTR into IR; go to EXEC.
- EXEC: drive IR opcode, ACC and R[r] into alu_core; register the result and flags; go to WB.
- WB: commit ACC, R, DOUT and flags per opcode; go to IDLE.
- Presses detected while BUSY are dropped, not queued.
- INSTR changes after FETCH do not affect the executing instruction.

## Timing
- Reset: ACC, R[0..3], DOUT, IR = 8'h00; SIG1 = SIG2 = 0; BUSY = 0; FSM in IDLE; synchronizer, debounced level and counter = 0.
- If STEP is held high across reset, it registers as a press once debounce completes after reset.
- Reset asserted mid-instruction aborts it; no partial commit.
- Latency: debounced rise in cycle N gives FETCH at N+1, EXEC at N+2, and ACC/DOUT/flags visible at N+4 (registered after WB).
- BUSY is high for N+1..N+3.
- From the raw STEP edge to the debounced rise: 2 synchronizer cycles plus DEB_CYCLES.
- Minimum press-to-press spacing for acceptance: 3 cycles after the debounced rise, plus the debounce time of the release and the next press.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_LDI..OP_XOR);
  - FSM state encoding;
  - data width 8.
- One sub-module, alu_core: purely combinational.
  - Inputs: op[3:0], a[7:0], b[7:0].
  - Outputs: y[7:0], c, z.
  - Instantiated once in the sequencer.
- Synchronizer, debounce and FSM stay inline.

## Test plan
- Reset, then presses with INSTR 0x1D, 0x20, 0x17, 0x40 -> ACC 0x14, R0 0x0D, SIG1 0, SIG2 0. Then 0x50 -> ACC 0x07. Then 0x60 -> ACC 0xF8.
- Continuing: 0x70 -> ACC 0x08; 0x80 -> ACC 0x0D; 0x90 -> ACC 0x00, SIG2 1; 0x30 -> DOUT 0x00. DOUT must remain 0x00 before the WRITE.
- Carry/borrow: 0x1F, 0x21, 0x60, 0x41 -> ACC 0xFF, SIG1 0. Then 0x41 -> ACC 0x0E, SIG1 1. Then 0x1F, 0x51 (0x0F - 0x0F) -> ACC 0x00, SIG1 0, SIG2 1. Then 0x12, 0x51 -> ACC 0xF3, SIG1 1.
- Bounce: STEP toggling every 2 cycles for 20 cycles, then stable high -> exactly one instruction executes. A glitch shorter than DEB_CYCLES -> nothing executes. A second debounced press while BUSY -> dropped.
- Invalid opcodes 0x00 and 0xF3 -> BUSY pulses for 3 cycles; ACC, R, DOUT and flags unchanged.
- RST asserted during EXEC of ADD -> all outputs 0, FSM in IDLE next cycle. A following press of 0x1A -> ACC 0x0A.
